// File: rtl/regfile_access_controller_pkg.sv
// regfile_access_controller_pkg: shared state/grant encodings and width defaults
package regfile_access_controller_pkg;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  typedef enum logic {S_INIT, S_RUN} state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_READ, GNT_WB0, GNT_WB1} gnt_t;
endpackage

// File: rtl/regfile_access_controller_if.sv
// regfile_access_controller_if: write-back, decode read and response handshakes
interface regfile_access_controller_if
  import regfile_access_controller_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic wb0_valid, wb1_valid, wb0_ready, wb1_ready;
  logic [ADDR_WIDTH-1:0] wb0_addr, wb1_addr;
  logic [DATA_WIDTH-1:0] wb0_data, wb1_data;
  logic rd_valid, rd_ready, rsp_valid;
  logic [ADDR_WIDTH-1:0] rd_addr_1, rd_addr_2;
  logic [DATA_WIDTH-1:0] rsp_data_1, rsp_data_2;
  modport master (
    output wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data, rd_valid, rd_addr_1, rd_addr_2,
    input wb0_ready, wb1_ready, rd_ready, rsp_valid, rsp_data_1, rsp_data_2
  );
  modport slave (
    input wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data, rd_valid, rd_addr_1, rd_addr_2,
    output wb0_ready, wb1_ready, rd_ready, rsp_valid, rsp_data_1, rsp_data_2
  );
endinterface

// File: rtl/regfile_wb_rr_arbiter.sv
// regfile_wb_rr_arbiter: 2-way round-robin arbiter for the write-back requesters
module regfile_wb_rr_arbiter (
  input  logic clock,
  input  logic reset,
  input  logic valid_0,
  input  logic valid_1,
  input  logic enable,
  output logic grant,
  output logic winner
);
  logic rr;
  always_comb begin
    grant = enable && (valid_0 || valid_1);
    winner = (valid_0 && valid_1) ? rr : valid_1;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) rr <= 1'b0;
    else if (grant) rr <= !winner;
endmodule

// File: rtl/regfile_access_controller.sv
// regfile_access_controller: register file write-port arbiter and read sequencer
module regfile_access_controller
  import regfile_access_controller_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int STREAK_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  regfile_access_controller_if.slave bus,
  output logic rf_reset,
  output logic rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_write_address,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [ADDR_WIDTH-1:0] rf_read_address_1,
  output logic [ADDR_WIDTH-1:0] rf_read_address_2,
  input  logic [DATA_WIDTH-1:0] rf_data_out_1,
  input  logic [DATA_WIDTH-1:0] rf_data_out_2
);
  localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);
  state_t state, state_nx;
  gnt_t gnt;
  logic [3:0] streak;
  logic run, any_wb, hazard, rd_gnt, wr, arb_gnt, arb_win, rsp_valid;
  logic [DATA_WIDTH-1:0] hold_1, hold_2;
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= S_INIT;
    else state <= state_nx;
  always_comb state_nx = (state == S_INIT) ? S_RUN : state;
  always_comb begin
    run = state == S_RUN;
    any_wb = bus.wb0_valid || bus.wb1_valid;
    hazard = bus.rd_valid &&
      ((bus.wb0_valid && (bus.wb0_addr == bus.rd_addr_1 || bus.wb0_addr == bus.rd_addr_2)) ||
       (bus.wb1_valid && (bus.wb1_addr == bus.rd_addr_1 || bus.wb1_addr == bus.rd_addr_2)));
    rd_gnt = run && bus.rd_valid && (!any_wb || (streak == STREAK_LIM && !hazard));
  end
  regfile_wb_rr_arbiter u_arb (
    .clock(clock), .reset(reset), .valid_0(bus.wb0_valid), .valid_1(bus.wb1_valid),
    .enable(run && !rd_gnt), .grant(arb_gnt), .winner(arb_win)
  );
  always_comb begin
    gnt = rd_gnt ? GNT_READ : arb_gnt ? (arb_win ? GNT_WB1 : GNT_WB0) : GNT_NONE;
    wr = gnt == GNT_WB0 || gnt == GNT_WB1;
    bus.wb0_ready = gnt == GNT_WB0;
    bus.wb1_ready = gnt == GNT_WB1;
    bus.rd_ready = gnt == GNT_READ;
    rf_reset = !run;
    rf_write_enable = wr;
    rf_write_address = (gnt == GNT_WB0) ? bus.wb0_addr : (gnt == GNT_WB1) ? bus.wb1_addr : '0;
    rf_write_data = (gnt == GNT_WB0) ? bus.wb0_data : (gnt == GNT_WB1) ? bus.wb1_data : '0;
    rf_read_address_1 = (run && !wr) ? bus.rd_addr_1 : '0;
    rf_read_address_2 = (run && !wr) ? bus.rd_addr_2 : '0;
    bus.rsp_valid = rsp_valid;
    bus.rsp_data_1 = rsp_valid ? rf_data_out_1 : hold_1;
    bus.rsp_data_2 = rsp_valid ? rf_data_out_2 : hold_2;
  end
  // Under a persistent hazard the streak parks at the limit so writes keep draining.
  always_ff @(posedge clock or negedge reset)
    if (!reset) streak <= '0;
    else if (!bus.rd_valid || gnt == GNT_READ) streak <= '0;
    else if (wr && streak != STREAK_LIM) streak <= streak + 4'd1;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      rsp_valid <= 1'b0;
      hold_1 <= '0;
      hold_2 <= '0;
    end else begin
      rsp_valid <= gnt == GNT_READ;
      if (rsp_valid) begin
        hold_1 <= rf_data_out_1;
        hold_2 <= rf_data_out_2;
      end
    end
endmodule
